// File: rtl/game_retract_stack_pkg.sv
// Shared definitions for the Sokoban undo history: board/snapshot widths and the
// per-cycle operation decode used by the retract stack.
package game_retract_stack_pkg;

   localparam int unsigned BOARD_CELLS = 64;
   localparam int unsigned MAN_W       = 6;
   // Snapshots are packed {box, man}, box in the MSBs, matching game_controller game_state.
   localparam int unsigned SNAP_W      = BOARD_CELLS + MAN_W;

   typedef enum logic [1:0] {
      OpIdle,
      OpClear,
      OpPop,
      OpPush
   } op_e;

   // Priority clear > pop > push; a pop on an empty history is a no-op and swallows the push.
   function automatic op_e decode_op(input logic clear, input logic push, input logic pop,
                                     input logic empty);
      if (clear)          return OpClear;
      if (pop && !empty)  return OpPop;
      if (pop)            return OpIdle;
      if (push)           return OpPush;
      return OpIdle;
   endfunction

endpackage

// File: rtl/game_retract_stack_if.sv
// Controller-facing bundle of the undo history: push/pop requests, the snapshot to store,
// and the restored snapshot with its status outputs.
interface game_retract_stack_if #(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned BOX_W = 64,
   parameter int unsigned MAN_W = 6
);
   localparam int unsigned DEPTH_W = $clog2(DEPTH) + 1;

   logic               clear;
   logic               push;
   logic               pop;
   logic [BOX_W-1:0]   cur_box;
   logic [MAN_W-1:0]   cur_man;
   logic [BOX_W-1:0]   prev_box;
   logic [MAN_W-1:0]   prev_man;
   logic               pop_valid;
   logic               real_retract;
   logic [DEPTH_W-1:0] depth;
   logic               push_drop;

   modport master (
      output clear, push, pop, cur_box, cur_man,
      input  prev_box, prev_man, pop_valid, real_retract, depth, push_drop
   );

   modport slave (
      input  clear, push, pop, cur_box, cur_man,
      output prev_box, prev_man, pop_valid, real_retract, depth, push_drop
   );

endinterface

// File: rtl/game_history_ram.sv
// Snapshot storage for the undo history: one write port and one registered read port,
// shaped so synthesis maps it onto block or distributed RAM.
module game_history_ram
   import game_retract_stack_pkg::*;
#(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned WIDTH = SNAP_W
) (
   input  logic                       i_clk,
   input  logic                       i_we,
   input  logic [$clog2(DEPTH)-1:0]   i_waddr,
   input  logic [WIDTH-1:0]           i_wdata,
   input  logic                       i_re,
   input  logic [$clog2(DEPTH)-1:0]   i_raddr,
   output logic [WIDTH-1:0]           o_rdata
);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [WIDTH-1:0] r_rdata;

   always_ff @(posedge i_clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_re) begin
         r_rdata <= r_mem[i_raddr];
      end
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/game_retract_stack.sv
// Undo history for the Sokoban core: ring buffer of {box,man} snapshots that overwrites the
// oldest entry when full and returns the newest one a cycle after each retract request.
module game_retract_stack
   import game_retract_stack_pkg::*;
#(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned BOX_W = BOARD_CELLS,
   parameter int unsigned MAN_W = 6
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   game_retract_stack_if.slave   bus
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned DW = AW + 1;
   localparam int unsigned SW = BOX_W + MAN_W;

   op_e           w_op;
   logic [AW-1:0] r_top;
   logic [AW-1:0] w_top_d;
   logic [AW-1:0] w_rd_addr;
   logic [DW-1:0] r_depth;
   logic [DW-1:0] w_depth_d;
   logic          w_we;
   logic          w_re;
   logic [SW-1:0] w_wdata;
   logic [SW-1:0] w_rdata;
   logic [SW-1:0] r_prev;
   logic          r_pop_valid;
   logic          r_push_drop;
   logic          r_real_retract;

   assign w_wdata   = {bus.cur_box, bus.cur_man};
   assign w_rd_addr = r_top - AW'(1);

   always_comb begin
      w_op      = decode_op(bus.clear, bus.push, bus.pop, r_depth == '0);
      w_top_d   = r_top;
      w_depth_d = r_depth;
      w_we      = 1'b0;
      w_re      = 1'b0;
      unique case (w_op)
         OpIdle: ;
         OpClear: begin
            w_top_d   = '0;
            w_depth_d = '0;
         end
         OpPop: begin
            w_re      = 1'b1;
            w_top_d   = r_top - AW'(1);
            w_depth_d = r_depth - DW'(1);
         end
         OpPush: begin
            // When full, the slot at top is the oldest entry, so writing there overwrites it.
            w_we      = 1'b1;
            w_top_d   = r_top + AW'(1);
            w_depth_d = (r_depth == DW'(DEPTH)) ? r_depth : r_depth + DW'(1);
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_top          <= '0;
         r_depth        <= '0;
         r_pop_valid    <= 1'b0;
         r_push_drop    <= 1'b0;
         r_real_retract <= 1'b0;
         r_prev         <= '0;
      end else begin
         r_top          <= w_top_d;
         r_depth        <= w_depth_d;
         r_pop_valid    <= (w_op == OpPop);
         r_push_drop    <= (w_op == OpPop) && bus.push;
         r_real_retract <= (w_depth_d != '0);
         if (w_op == OpClear) begin
            r_prev <= '0;
         end else if (r_pop_valid) begin
            r_prev <= w_rdata;
         end
      end
   end

   game_history_ram #(
      .DEPTH (DEPTH),
      .WIDTH (SW)
   ) u_ram (
      .i_clk   (i_clk),
      .i_we    (w_we),
      .i_waddr (r_top),
      .i_wdata (w_wdata),
      .i_re    (w_re),
      .i_raddr (w_rd_addr),
      .o_rdata (w_rdata)
   );

   // The RAM read register carries the snapshot during the pop_valid cycle; r_prev holds it after.
   assign {bus.prev_box, bus.prev_man} = r_pop_valid ? w_rdata : r_prev;
   assign bus.pop_valid    = r_pop_valid;
   assign bus.push_drop    = r_push_drop;
   assign bus.real_retract = r_real_retract;
   assign bus.depth        = r_depth;

endmodule

// File: tb/tb_game_retract_stack.sv
// Randomized scoreboard bench for game_retract_stack: a queue-based history model predicts
// each restored snapshot; a negedge monitor checks every cycle's outputs against it.
module tb_game_retract_stack;

   localparam int unsigned DEPTH = 16;
   localparam int unsigned BOX_W = 64;
   localparam int unsigned MAN_W = 6;

   typedef struct {
      int               kind;   // 0: restored snapshot, 1: clear/reset
      logic [BOX_W-1:0] box;
      logic [MAN_W-1:0] man;
      bit               drop;
      int               due;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;

   exp_t                   exp_q[$];
   logic [BOX_W+MAN_W-1:0] hist[$];
   logic [BOX_W-1:0]       last_box;
   logic [MAN_W-1:0]       last_man;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   game_retract_stack_if #(.DEPTH(DEPTH), .BOX_W(BOX_W), .MAN_W(MAN_W)) bus ();

   game_retract_stack #(
      .DEPTH (DEPTH),
      .BOX_W (BOX_W),
      .MAN_W (MAN_W)
   ) dut (
      .i_clk   (clk),
      .i_reset (reset),
      .bus     (bus)
   );

   task automatic check(input string name, input logic [BOX_W+MAN_W-1:0] act,
                        input logic [BOX_W+MAN_W-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: outputs are stable at negedge; an expectation is due on the cycle after issue.
   always @(negedge clk) begin
      exp_t e;
      if (cyc > 0) begin
         if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            e = exp_q.pop_front();
            if (e.kind == 1) begin
               last_box = '0;
               last_man = '0;
               check("clear_pop_valid", bus.pop_valid, 0);
               check("clear_push_drop", bus.push_drop, 0);
               check("clear_prev", {bus.prev_box, bus.prev_man}, 0);
            end else begin
               check("pop_valid", bus.pop_valid, 1);
               check("push_drop", bus.push_drop, e.drop);
               check("prev_box", bus.prev_box, e.box);
               check("prev_man", bus.prev_man, e.man);
               last_box = e.box;
               last_man = e.man;
            end
         end else begin
            check("idle_pop_valid", bus.pop_valid, 0);
            check("idle_push_drop", bus.push_drop, 0);
            check("prev_hold", {bus.prev_box, bus.prev_man}, {last_box, last_man});
         end
      end
   end

   // One cycle of stimulus; the model applies the specified priority and ring behaviour.
   task automatic step(input bit rst, input bit clr, input bit psh, input bit pp,
                       input logic [BOX_W-1:0] b, input logic [MAN_W-1:0] m);
      logic [BOX_W+MAN_W-1:0] s;
      reset       = rst;
      bus.clear   = clr;
      bus.push    = psh;
      bus.pop     = pp;
      bus.cur_box = b;
      bus.cur_man = m;
      if (rst || clr) begin
         hist.delete();
         exp_q.push_back('{kind: 1, box: '0, man: '0, drop: 1'b0, due: cyc + 1});
      end else if (pp) begin
         if (hist.size() > 0) begin
            s = hist.pop_back();
            exp_q.push_back('{kind: 0, box: s[BOX_W+MAN_W-1:MAN_W], man: s[MAN_W-1:0],
                              drop: psh, due: cyc + 1});
         end
      end else if (psh) begin
         hist.push_back({b, m});
         if (hist.size() > DEPTH) void'(hist.pop_front());
      end
      @(posedge clk);
      #2;
      check("depth", bus.depth, hist.size());
      check("real_retract", bus.real_retract, hist.size() != 0);
   endtask

   task automatic push_v(input logic [BOX_W-1:0] b, input logic [MAN_W-1:0] m);
      step(0, 0, 1, 0, b, m);
   endtask

   task automatic pop_v();
      step(0, 0, 0, 1, '0, '0);
   endtask

   task automatic idle();
      step(0, 0, 0, 0, '0, '0);
   endtask

   initial begin
      int r;
      last_box = '0;
      last_man = '0;

      // Reset and pop on empty history
      for (int i = 0; i < 3; i++) step(1, 0, 0, 0, '0, '0);
      pop_v();
      idle();

      // Two pushes, two pops
      push_v(64'd1, 6'd0);
      push_v(64'd2, 6'd9);
      pop_v();
      pop_v();
      idle();

      // Overflow: oldest entries overwritten, 17th pop finds nothing
      for (int k = 1; k <= 20; k++) push_v(64'(k), 6'(k));
      for (int k = 0; k < 17; k++) pop_v();
      idle();

      // Push/pop collision: push discarded and flagged
      push_v(64'd10, 6'd1);
      push_v(64'd11, 6'd2);
      push_v(64'd12, 6'd3);
      step(0, 0, 1, 1, 64'hFF, 6'd63);
      for (int k = 0; k < 3; k++) pop_v();
      idle();

      // Clear with push, then reset in the middle of pops
      for (int k = 0; k < 5; k++) push_v(64'(100 + k), 6'(k));
      step(0, 1, 1, 0, 64'hDEAD, 6'd5);
      for (int k = 0; k < 3; k++) push_v(64'(200 + k), 6'(k + 7));
      pop_v();
      pop_v();
      step(1, 0, 0, 1, '0, '0);
      idle();

      // Push-push-pop pattern drifts top across the 15->0 wrap
      for (int i = 0; i < 40; i++) begin
         if (i % 3 != 2) push_v({$urandom, $urandom}, 6'($urandom_range(0, 63)));
         else            pop_v();
      end

      // Random mix
      for (int i = 0; i < 400; i++) begin
         r = int'($urandom_range(0, 99));
         if (r < 3)
            step(0, 1, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, '1, '1);
         else if (r < 35)
            pop_v();
         else if (r < 40 && hist.size() > 0)
            step(0, 0, 1, 1, {$urandom, $urandom}, 6'($urandom_range(0, 63)));
         else if (r < 88)
            push_v({$urandom, $urandom}, 6'($urandom_range(0, 63)));
         else
            idle();
      end

      idle();
      idle();
      check("queue_drained", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
